// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog controller and the watchdog beside it:
// controller state encoding, register offsets and the register readback mux.
package wdt_pkg;

  typedef logic [1:0] wdt_state_t;

  localparam wdt_state_t IDLE  = 2'd0;
  localparam wdt_state_t ISSUE = 2'd1;
  localparam wdt_state_t RESP  = 2'd2;

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_KICK    = 4'h4;
  localparam logic [3:0] ADDR_TIMEOUT = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'hC;

  // Readback value of a register; KICK and unmapped offsets read as zero.
  function automatic logic [31:0] reg_read(
    input logic [3:0]  addr,
    input logic        wden,
    input logic        ie,
    input logic [31:0] timeout,
    input logic        pend,
    input logic        level
  );
    logic [31:0] val;
    case (addr)
      ADDR_CTRL:    val = {30'd0, ie, wden};
      ADDR_TIMEOUT: val = timeout;
      ADDR_STATUS:  val = {30'd0, level, pend};
      default:      val = 32'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/wdt_ctrl.sv
// Watchdog controller: bus-slave register block that forwards CTRL, KICK and
// TIMEOUT writes to the watchdog over ready/valid channels, keeps shadow copies
// of what the watchdog accepted, and turns watchdog interrupts into irq_out.
module wdt_ctrl
  import wdt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wden_valid,
  input  logic        wden_ready,
  output logic        wden,
  output logic        wdlive_valid,
  input  logic        wdlive_ready,
  output logic        wdlive,
  output logic        wtocnt_valid,
  input  logic        wtocnt_ready,
  output logic [31:0] wtocnt,
  input  logic        irq_valid,
  output logic        irq_ready,
  input  logic        irq_level,
  output logic        irq_out
);

  wdt_state_t  state_r;
  logic        ctrl_wden_r;
  logic        ctrl_ie_r;
  logic        ie_pend_r;     // IE bit of an in-flight CTRL write
  logic [31:0] timeout_r;
  logic        pend_r;
  logic        level_r;

  logic        accept_s;
  logic        misaligned_s;
  logic        ctrl_reject_s;
  logic        issue_hs_s;
  logic        irq_set_s;
  logic        pend_clr_s;
  logic [31:0] rd_mux_s;

  assign req_ready = (state_r == IDLE);
  assign irq_ready = 1'b1;
  assign irq_out   = pend_r & ctrl_ie_r;

  // Request decode and downstream handshake detection.
  always_comb begin
    accept_s      = req_valid && (state_r == IDLE);
    misaligned_s  = (req_addr[1:0] != 2'b00);
    ctrl_reject_s = req_write && (req_addr == ADDR_CTRL) && req_wdata[0] &&
                    (timeout_r == 32'd0);
    issue_hs_s    = (wden_valid && wden_ready) || (wdlive_valid && wdlive_ready) ||
                    (wtocnt_valid && wtocnt_ready);
    irq_set_s     = irq_valid && irq_level;
    pend_clr_s    = accept_s && req_write && (req_addr == ADDR_STATUS) && req_wdata[0];
    rd_mux_s      = reg_read(req_addr, ctrl_wden_r, ctrl_ie_r, timeout_r, pend_r, level_r);
  end

  // Transaction FSM: accept, drive one downstream channel, then respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ctrl_wden_r  <= 1'b0;
      ctrl_ie_r    <= 1'b0;
      ie_pend_r    <= 1'b0;
      timeout_r    <= 32'd0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      wden_valid   <= 1'b0;
      wden         <= 1'b0;
      wdlive_valid <= 1'b0;
      wdlive       <= 1'b0;
      wtocnt_valid <= 1'b0;
      wtocnt       <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (misaligned_s || ctrl_reject_s) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
              state_r   <= RESP;
            end else if (!req_write) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= rd_mux_s;
              state_r   <= RESP;
            end else begin
              case (req_addr)
                ADDR_CTRL: begin
                  wden_valid <= 1'b1;
                  wden       <= req_wdata[0];
                  ie_pend_r  <= req_wdata[1];
                  state_r    <= ISSUE;
                end
                ADDR_KICK: begin
                  wdlive_valid <= 1'b1;
                  wdlive       <= 1'b1;
                  state_r      <= ISSUE;
                end
                ADDR_TIMEOUT: begin
                  wtocnt_valid <= 1'b1;
                  wtocnt       <= req_wdata;
                  state_r      <= ISSUE;
                end
                default: begin
                  // STATUS write: PEND clear is handled with the irq flops.
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= 32'd0;
                  state_r   <= RESP;
                end
              endcase
            end
          end
        end
        ISSUE: begin
          if (issue_hs_s) begin
            // Shadows follow what the watchdog actually took.
            if (wden_valid) begin
              ctrl_wden_r <= wden;
              ctrl_ie_r   <= ie_pend_r;
            end
            if (wtocnt_valid) begin
              timeout_r <= wtocnt;
            end
            wden_valid   <= 1'b0;
            wdlive_valid <= 1'b0;
            wdlive       <= 1'b0;
            wtocnt_valid <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b0;
            rsp_rdata    <= 32'd0;
            state_r      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            state_r   <= IDLE;
          end
        end
        default: begin
          wden_valid   <= 1'b0;
          wdlive_valid <= 1'b0;
          wtocnt_valid <= 1'b0;
          rsp_valid    <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // Interrupt status: LEVEL tracks the last irq, PEND is W1C with set priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r  <= 1'b0;
      level_r <= 1'b0;
    end else begin
      if (irq_valid) begin
        level_r <= irq_level;
      end
      if (irq_set_s) begin
        pend_r <= 1'b1;
      end else if (pend_clr_s) begin
        pend_r <= 1'b0;
      end
    end
  end

endmodule
